// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, control-sequencer state
// encoding and the bundle of control strobes it drives.
package cpu_pkg;

    // Opcode field IR[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Sequencer states; T0..T7 are contiguous so the step number is state-7
    typedef enum logic [3:0] {
        S_RESET = 4'b0000,
        S_T0    = 4'b0111,
        S_T1    = 4'b1000,
        S_T2    = 4'b1001,
        S_T3    = 4'b1010,
        S_T4    = 4'b1011,
        S_T5    = 4'b1100,
        S_T6    = 4'b1101,
        S_T7    = 4'b1110,
        S_HALT  = 4'b1111
    } state_t;

    // All control strobes of the datapath, decoded together per state
    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic zlow_in;
        logic zlow_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic ram_we;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        logic y_in;
        logic inport_out;
        logic outport_in;
    } ctrl_t;

    // Two-operand ALU instructions share one register-register sequence
    function automatic logic is_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Instructions that form an address/immediate from Rb plus the C field
    function automatic logic is_imm(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch in T0-T2, opcode-specific execute in
// T3-T7, with a sticky HALT state left only through clr.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] operation,
    output logic       PCout,
    output logic       MARin,
    output logic       IncPC,
    output logic       ZLowIn,
    output logic       ZLowout,
    output logic       PCin,
    output logic       Read,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       ramWE,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       BAout,
    output logic       Cout,
    output logic       Yin,
    output logic       InPortout,
    output logic       OutPortIn,
    output logic       run,
    output logic [3:0] state_dbg
);

    state_t     state_reg, state_next;
    logic [4:0] op_reg, op_next;
    ctrl_t      ctrl;

    // The opcode is captured on the same edge that loads IR (entry to T3),
    // so the T3 decode and every later step see a registered value only.
    assign op_next = (state_reg == S_T2) ? operation : op_reg;

    // State and op registers; clr overrides every transition
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= S_RESET;
            op_reg    <= OP_NOP;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
        end
    end

    // Next-state and control decode from the registered state and op only
    always_comb begin
        ctrl       = '0;
        state_next = S_RESET;
        case (state_reg)
            S_RESET: state_next = S_T0;
            S_T0: begin
                ctrl.pc_out  = 1'b1;
                ctrl.mar_in  = 1'b1;
                ctrl.inc_pc  = 1'b1;
                ctrl.zlow_in = 1'b1;
                state_next   = S_T1;
            end
            S_T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = 1'b1;
                state_next    = S_T2;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                state_next   = S_T3;
            end
            S_T3: begin
                state_next = S_T0;
                if (op_reg == OP_IN) begin
                    ctrl.gra        = 1'b1;
                    ctrl.r_in       = 1'b1;
                    ctrl.inport_out = 1'b1;
                end else if (op_reg == OP_OUT) begin
                    ctrl.gra        = 1'b1;
                    ctrl.r_out      = 1'b1;
                    ctrl.outport_in = 1'b1;
                end else if (is_alu(op_reg)) begin
                    ctrl.grb   = 1'b1;
                    ctrl.r_out = 1'b1;
                    ctrl.y_in  = 1'b1;
                    state_next = S_T4;
                end else if (is_imm(op_reg)) begin
                    ctrl.grb    = 1'b1;
                    ctrl.ba_out = 1'b1;
                    ctrl.y_in   = 1'b1;
                    state_next  = S_T4;
                end else if (op_reg == OP_HALT) begin
                    state_next = S_HALT;
                end
            end
            S_T4: begin
                state_next   = S_T5;
                ctrl.zlow_in = 1'b1;
                if (is_alu(op_reg)) begin
                    ctrl.grc   = 1'b1;
                    ctrl.r_out = 1'b1;
                end else begin
                    ctrl.c_out = 1'b1;
                end
            end
            S_T5: begin
                ctrl.zlow_out = 1'b1;
                if (op_reg == OP_LD || op_reg == OP_ST) begin
                    ctrl.mar_in = 1'b1;
                    state_next  = S_T6;
                end else begin
                    ctrl.gra   = 1'b1;
                    ctrl.r_in  = 1'b1;
                    state_next = S_T0;
                end
            end
            S_T6: begin
                state_next  = S_T7;
                ctrl.mdr_in = 1'b1;
                if (op_reg == OP_ST) begin
                    ctrl.gra   = 1'b1;
                    ctrl.r_out = 1'b1;
                end else begin
                    ctrl.read = 1'b1;
                end
            end
            S_T7: begin
                state_next = S_T0;
                if (op_reg == OP_ST) begin
                    ctrl.ram_we = 1'b1;
                end else begin
                    ctrl.mdr_out = 1'b1;
                    ctrl.gra     = 1'b1;
                    ctrl.r_in    = 1'b1;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    assign PCout     = ctrl.pc_out;
    assign MARin     = ctrl.mar_in;
    assign IncPC     = ctrl.inc_pc;
    assign ZLowIn    = ctrl.zlow_in;
    assign ZLowout   = ctrl.zlow_out;
    assign PCin      = ctrl.pc_in;
    assign Read      = ctrl.read;
    assign MDRin     = ctrl.mdr_in;
    assign MDRout    = ctrl.mdr_out;
    assign IRin      = ctrl.ir_in;
    assign ramWE     = ctrl.ram_we;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign BAout     = ctrl.ba_out;
    assign Cout      = ctrl.c_out;
    assign Yin       = ctrl.y_in;
    assign InPortout = ctrl.inport_out;
    assign OutPortIn = ctrl.outport_in;

    assign run       = (state_reg != S_RESET) && (state_reg != S_HALT);
    assign state_dbg = state_reg;

endmodule
